ex_muldiv: RTL and testbench

Iterative RV32M multiply/divide unit in the execute stage. It is fed directly from the ID/EX pipeline register outputs (operand values, destination register, funct3) and produces one 32-bit result per accepted operation. While an operation is in flight it drives `busy`, which the hazard logic ORs into the load-use stall path so that IF/ID and ID/EX hold. It honours the global cache-stall freeze exactly like the pipeline registers do.

---
 rtl/ex_muldiv.sv | 199 +++++++++++++++++++
 tb/tb_ex_muldiv.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative RV32M multiply/divide unit for the execute stage.
// Multiplies by radix-2 shift-add and divides by restoring division, one bit
// per cycle over 32 cycles. Divide-by-zero and signed overflow bypass the loop.
// Ports:
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_start, i_op         M-extension op request and its funct3
//   i_rs1_value/rs2_value operands A and B
//   i_rd_addr_in          destination register
//   i_cache_stall         global freeze, holds all state
//   o_busy                stall request toward IF/ID and ID/EX
//   o_result_valid        result and destination are valid (DONE state)
//   o_result, o_rd_addr_out
module ex_muldiv #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_start,
    input  logic [2:0]      i_op,
    input  logic [XLEN-1:0] i_rs1_value,
    input  logic [XLEN-1:0] i_rs2_value,
    input  logic [4:0]      i_rd_addr_in,
    input  logic            i_cache_stall,
    output logic            o_busy,
    output logic            o_result_valid,
    output logic [XLEN-1:0] o_result,
    output logic [4:0]      o_rd_addr_out
);

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_DONE} state_t;

    state_t              r_state;
    logic [4:0]          r_count;
    logic [2:0]          r_op;
    logic [4:0]          r_rd;
    logic                r_sign_a;
    logic                r_sign_b;
    // Multiply: {partial product, remaining multiplier bits}.
    // Divide:   {partial remainder, dividend shifting out / quotient shifting in}.
    logic [2*XLEN-1:0]   r_acc;
    // Multiplicand magnitude for multiplies, divisor magnitude for divides.
    logic [XLEN-1:0]     r_operand;
    logic                r_result_valid;
    logic [XLEN-1:0]     r_result;
    logic [4:0]          r_rd_addr_out;

    logic                w_is_div;
    logic                w_a_signed;
    logic                w_b_signed;
    logic                w_sign_a;
    logic                w_sign_b;
    logic [XLEN-1:0]     w_mag_a;
    logic [XLEN-1:0]     w_mag_b;
    logic                w_div_zero;
    logic                w_overflow;
    logic [XLEN-1:0]     w_fast_result;

    logic [XLEN:0]       w_mul_sum;
    logic [2*XLEN-1:0]   w_mul_next;
    logic [XLEN:0]       w_rem_shift;
    logic                w_rem_ge;
    logic [XLEN-1:0]     w_rem_sub;
    logic [2*XLEN-1:0]   w_div_next;
    logic [2*XLEN-1:0]   w_acc_next;

    logic                w_neg;
    logic [2*XLEN-1:0]   w_prod_fix;
    logic [XLEN-1:0]     w_quot_fix;
    logic [XLEN-1:0]     w_rem_fix;
    logic [XLEN-1:0]     w_calc_result;

    assign o_busy         = (r_state == ST_CALC) ||
                            ((r_state == ST_IDLE) && i_start && !i_cache_stall);
    assign o_result_valid = r_result_valid;
    assign o_result       = r_result;
    assign o_rd_addr_out  = r_rd_addr_out;

    // Operand decode: MULHU/DIVU/REMU are fully unsigned, MULHSU only signs A.
    assign w_is_div   = i_op[2];
    assign w_a_signed = w_is_div ? !i_op[0] : (i_op[1:0] != 2'b11);
    assign w_b_signed = w_is_div ? !i_op[0] : !i_op[1];
    assign w_sign_a   = w_a_signed && i_rs1_value[XLEN-1];
    assign w_sign_b   = w_b_signed && i_rs2_value[XLEN-1];
    assign w_mag_a    = w_sign_a ? -i_rs1_value : i_rs1_value;
    assign w_mag_b    = w_sign_b ? -i_rs2_value : i_rs2_value;

    assign w_div_zero = w_is_div && (i_rs2_value == '0);
    assign w_overflow = w_is_div && !i_op[0] &&
                        (i_rs1_value == INT_MIN) && (i_rs2_value == '1);
    always_comb begin
        w_fast_result = '0;
        if (w_div_zero)
            w_fast_result = i_op[1] ? i_rs1_value : '1;
        else
            w_fast_result = i_op[1] ? '0 : INT_MIN;
    end

    // One shift-add step: add multiplicand when the multiplier LSB is set.
    assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} +
                        (r_acc[0] ? {1'b0, r_operand} : '0);
    assign w_mul_next = {w_mul_sum, r_acc[XLEN-1:1]};

    // One restoring step: the partial remainder is always below the divisor,
    // so when the trial subtraction succeeds the difference fits in XLEN bits.
    assign w_rem_shift = r_acc[2*XLEN-1:XLEN-1];
    assign w_rem_ge    = (w_rem_shift >= {1'b0, r_operand});
    assign w_rem_sub   = w_rem_shift[XLEN-1:0] - r_operand;
    assign w_div_next  = w_rem_ge ? {w_rem_sub, r_acc[XLEN-2:0], 1'b1}
                                  : {w_rem_shift[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};

    assign w_acc_next = r_op[2] ? w_div_next : w_mul_next;

    assign w_neg      = r_sign_a ^ r_sign_b;
    assign w_prod_fix = w_neg ? -w_acc_next : w_acc_next;
    assign w_quot_fix = w_neg ? -w_acc_next[XLEN-1:0] : w_acc_next[XLEN-1:0];
    assign w_rem_fix  = r_sign_a ? -w_acc_next[2*XLEN-1:XLEN]
                                 : w_acc_next[2*XLEN-1:XLEN];

    always_comb begin
        w_calc_result = '0;
        case (r_op)
            OP_MUL:                        w_calc_result = w_prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  w_calc_result = w_prod_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:               w_calc_result = w_quot_fix;
            OP_REM, OP_REMU:               w_calc_result = w_rem_fix;
            default:                       w_calc_result = '0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state        <= ST_IDLE;
            r_count        <= '0;
            r_op           <= '0;
            r_rd           <= '0;
            r_sign_a       <= 1'b0;
            r_sign_b       <= 1'b0;
            r_acc          <= '0;
            r_operand      <= '0;
            r_result_valid <= 1'b0;
            r_result       <= '0;
            r_rd_addr_out  <= '0;
        end else if (!i_cache_stall) begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_op     <= i_op;
                        r_rd     <= i_rd_addr_in;
                        r_sign_a <= w_sign_a;
                        r_sign_b <= w_sign_b;
                        if (w_div_zero || w_overflow) begin
                            r_result       <= w_fast_result;
                            r_rd_addr_out  <= i_rd_addr_in;
                            r_result_valid <= 1'b1;
                            r_state        <= ST_DONE;
                        end else begin
                            r_acc     <= w_is_div ? {{XLEN{1'b0}}, w_mag_a}
                                                  : {{XLEN{1'b0}}, w_mag_b};
                            r_operand <= w_is_div ? w_mag_b : w_mag_a;
                            r_count   <= 5'd31;
                            r_state   <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    r_acc <= w_acc_next;
                    if (r_count == 5'd0) begin
                        r_result       <= w_calc_result;
                        r_rd_addr_out  <= r_rd;
                        r_result_valid <= 1'b1;
                        r_state        <= ST_DONE;
                    end else begin
                        r_count <= r_count - 5'd1;
                    end
                end
                ST_DONE: begin
                    r_result_valid <= 1'b0;
                    r_state        <= ST_IDLE;
                end
                default: begin
                    r_result_valid <= 1'b0;
                    r_state        <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: directed-vector bench for ex_muldiv with hand-computed results,
// latencies, stall behaviour and mid-operation reset.
module tb_ex_muldiv;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic [4:0]  rd;
    logic        cache_stall;
    logic        busy;
    logic        result_valid;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int n_vec = 0;
    int n_miscompare = 0;

    ex_muldiv #(.XLEN(32)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_start        (start),
        .i_op           (op),
        .i_rs1_value    (a),
        .i_rs2_value    (b),
        .i_rd_addr_in   (rd),
        .i_cache_stall  (cache_stall),
        .o_busy         (busy),
        .o_result_valid (result_valid),
        .o_result       (result),
        .o_rd_addr_out  (rd_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miscompare++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called #1 after a rising edge with the unit idle. exp_lat counts edges
    // after the start edge until result_valid is seen (32 normal, 0 fast path).
    task automatic run_op(input string tag, input logic [2:0] f3,
                          input logic [31:0] va, input logic [31:0] vb,
                          input logic [4:0] vrd, input logic [31:0] exp,
                          input int exp_lat, input bit pulse_start);
        int n;
        op = f3; a = va; b = vb; rd = vrd; start = 1'b1;
        #1;
        chk({tag, "/busy_req"}, busy, 1);
        @(posedge clk); #1;
        start = 1'b0;
        a = 32'h1234_5678; b = 32'h0000_0003; op = 3'd0; rd = 5'd0;
        if (exp_lat > 0) chk({tag, "/busy_calc"}, busy, 1);
        n = 0;
        while (!result_valid && n < 60) begin
            start = pulse_start && (n >= 2) && (n < 8);
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        chk({tag, "/latency"}, n, exp_lat);
        chk({tag, "/result"}, result, exp);
        chk({tag, "/rd"}, rd_out, vrd);
        chk({tag, "/busy_done"}, busy, 0);
        @(posedge clk); #1;
        chk({tag, "/valid_1cyc"}, result_valid, 0);
        chk({tag, "/busy_idle"}, busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int cnt;
        rst_n = 1'b0; start = 1'b0; cache_stall = 1'b0;
        op = '0; a = '0; b = '0; rd = '0;
        #12;
        chk("reset/busy", busy, 0);
        chk("reset/valid", result_valid, 0);
        chk("reset/result", result, 0);
        chk("reset/rd", rd_out, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("mul_7_m3",   3'd0, 32'd7,          32'hFFFF_FFFD, 5'd1,  32'hFFFF_FFEB, 32, 0);
        run_op("mul_big",    3'd0, 32'h1234_5678,  32'h0000_0010, 5'd2,  32'h2345_6780, 32, 0);
        run_op("mulhu_ff",   3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFE, 32, 0);
        run_op("mulh_ff",    3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd4,  32'h0000_0000, 32, 0);
        run_op("mulhsu_ff",  3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd5,  32'hFFFF_FFFF, 32, 0);
        run_op("mulhu_2^31", 3'd3, 32'h8000_0000,  32'h0000_0004, 5'd6,  32'h0000_0002, 32, 0);
        run_op("div_m7_2",   3'd4, 32'hFFFF_FFF9,  32'd2,         5'd7,  32'hFFFF_FFFD, 32, 0);
        run_op("rem_m7_2",   3'd6, 32'hFFFF_FFF9,  32'd2,         5'd8,  32'hFFFF_FFFF, 32, 0);
        run_op("divu_100_7", 3'd5, 32'd100,        32'd7,         5'd9,  32'd14,        32, 0);
        run_op("remu_100_7", 3'd7, 32'd100,        32'd7,         5'd10, 32'd2,         32, 0);
        run_op("divu_by0",   3'd5, 32'd5,          32'd0,         5'd11, 32'hFFFF_FFFF, 0,  0);
        run_op("rem_by0",    3'd6, 32'd5,          32'd0,         5'd12, 32'd5,         0,  0);
        run_op("div_ovf",    3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 5'd13, 32'h8000_0000, 0,  0);
        run_op("rem_ovf",    3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 5'd14, 32'h0000_0000, 0,  0);
        run_op("divu_pulse", 3'd5, 32'd100,        32'd7,         5'd15, 32'd14,        32, 1);

        // MUL 3x5 with a 5-cycle stall mid-CALC, then a 3-cycle stall in DONE.
        op = 3'd0; a = 32'd3; b = 32'd5; rd = 5'd16; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        repeat (10) begin @(posedge clk); #1; n++; end
        cache_stall = 1'b1;
        repeat (5) begin @(posedge clk); #1; n++; end
        chk("stall/busy_calc", busy, 1);
        cache_stall = 1'b0;
        while (!result_valid && n < 80) begin @(posedge clk); #1; n++; end
        chk("stall/latency", n, 37);
        chk("stall/result", result, 15);
        cnt = 0;
        while (result_valid && cnt < 20) begin
            cnt++;
            chk("stall/busy_done", busy, 0);
            chk("stall/result_hold", result, 15);
            cache_stall = (cnt <= 3);
            @(posedge clk); #1;
        end
        cache_stall = 1'b0;
        chk("stall/valid_cycles", cnt, 4);

        // Reset in the middle of a DIVU.
        op = 3'd5; a = 32'h0000_FFFF; b = 32'd3; rd = 5'd17; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        chk("rst_mid/busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid/busy", busy, 0);
        chk("rst_mid/valid", result_valid, 0);
        chk("rst_mid/result", result, 0);
        chk("rst_mid/rd", rd_out, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid/after_release", result_valid, 0);
        run_op("mul_2_2", 3'd0, 32'd2, 32'd2, 5'd18, 32'd4, 32, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscompare);
        $finish;
    end

endmodule
